// File: rtl/adbg_ahb3_pkg.sv
// rtl/adbg_ahb3_pkg.sv - AHB3 encodings, arbiter state type and transfer legality check
package adbg_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [3:0] HPROT_DATA    = 4'b0001;
    localparam logic [3:0] HPROT_PRIV    = 4'b0010;
    localparam logic [3:0] HPROT_DEFAULT = HPROT_DATA | HPROT_PRIV;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FAIL} arb_state_t;

    // A transfer is rejected when it is wider than the bus or not naturally aligned.
    function automatic logic xfer_bad(input logic [7:0] addr_lo,
                                      input logic [2:0] size,
                                      input logic [2:0] max_size);
        logic [7:0] mask;
        mask = (8'd1 << size) - 8'd1;
        return (size > max_size) || ((addr_lo & mask) != 8'd0);
    endfunction

endpackage

// File: rtl/adbg_ahb3_arb_pick.sv
// rtl/adbg_ahb3_arb_pick.sv - fixed-priority requester selection with starvation guard
module adbg_ahb3_arb_pick #(
    parameter int MAX_CONSEC = 4
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic [1:0] req_i,
    input  logic [1:0] ack_i,
    input  logic       take_i,
    output logic       gnt_idx_o,
    output logic       gnt_vld_o
);

    localparam logic [3:0] SAT = 4'(MAX_CONSEC);

    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic [1:0] elig;

    // Priority is decided on raw requests; a winner that is in its ack cycle
    // is simply not granted, so the other requester cannot sneak in early.
    always_comb begin
        elig      = req_i & ~ack_i;
        gnt_idx_o = req_i[1] && (!req_i[0] || (starve_q == SAT));
        gnt_vld_o = elig[gnt_idx_o];
    end

    always_comb begin
        starve_d = starve_q;
        if (!req_i[1]) begin
            starve_d = 4'd0;
        end else if (take_i) begin
            if (gnt_idx_o) begin
                starve_d = 4'd0;
            end else if (starve_q < SAT) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/adbg_ahb3_arb.sv
// rtl/adbg_ahb3_arb.sv - two-requester single-beat AHB3 master sequencer
module adbg_ahb3_arb
    import adbg_ahb3_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CONSEC = 4
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [1:0]                  req,
    input  logic [1:0][ADDR_WIDTH-1:0]  addr,
    input  logic [1:0][DATA_WIDTH-1:0]  wdata,
    input  logic [1:0]                  we,
    input  logic [1:0][2:0]             size,
    output logic [1:0]                  ack,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        err,
    output logic                        HSEL,
    output logic [ADDR_WIDTH-1:0]       HADDR,
    output logic [DATA_WIDTH-1:0]       HWDATA,
    input  logic [DATA_WIDTH-1:0]       HRDATA,
    output logic                        HWRITE,
    output logic [2:0]                  HSIZE,
    output logic [2:0]                  HBURST,
    output logic [3:0]                  HPROT,
    output logic [1:0]                  HTRANS,
    output logic                        HMASTLOCK,
    input  logic                        HREADY,
    input  logic                        HRESP
);

    localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;

    arb_state_t            state_q;
    logic                  gnt_q;
    logic [1:0]            ack_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [1:0]            htrans_q;

    logic gnt_idx;
    logic gnt_vld;
    logic take;

    assign take = (state_q == IDLE) && gnt_vld;

    adbg_ahb3_arb_pick #(
        .MAX_CONSEC (MAX_CONSEC)
    ) u_pick (
        .clk_i     (HCLK),
        .resetn_i  (HRESETn),
        .req_i     (req),
        .ack_i     (ack_q),
        .take_i    (take),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            ack_q    <= 2'b00;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_WORD;
            htrans_q <= HTRANS_IDLE;
        end else begin
            ack_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        gnt_q <= gnt_idx;
                        if (xfer_bad(addr[gnt_idx][7:0], size[gnt_idx], MAX_SIZE)) begin
                            state_q <= FAIL;
                        end else begin
                            haddr_q  <= addr[gnt_idx];
                            hwrite_q <= we[gnt_idx];
                            hsize_q  <= size[gnt_idx];
                            htrans_q <= HTRANS_NONSEQ;
                            state_q  <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (HREADY) begin
                        htrans_q <= HTRANS_IDLE;
                        hwdata_q <= wdata[gnt_q];
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    // HRESP is only meaningful on the HREADY-high cycle of an error response.
                    if (HREADY) begin
                        ack_q[gnt_q] <= 1'b1;
                        err_q        <= HRESP;
                        if (!hwrite_q) begin
                            rdata_q <= HRDATA;
                        end
                        state_q <= IDLE;
                    end
                end
                FAIL: begin
                    ack_q[gnt_q] <= 1'b1;
                    err_q        <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign HSEL      = 1'b1;
    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HTRANS    = htrans_q;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_adbg_ahb3_arb.sv
// tb/tb_adbg_ahb3_arb.sv - scoreboard bench for adbg_ahb3_arb
module tb_adbg_ahb3_arb;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic [1:0]       req;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0]       we;
    logic [1:0][2:0]  size;
    logic [1:0]       ack;
    logic [31:0]      rdata;
    logic             err;
    logic             HSEL;
    logic [31:0]      HADDR;
    logic [31:0]      HWDATA;
    logic [31:0]      HRDATA;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [3:0]       HPROT;
    logic [1:0]       HTRANS;
    logic             HMASTLOCK;
    logic             HREADY;
    logic             HRESP;

    adbg_ahb3_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_CONSEC(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .addr(addr), .wdata(wdata),
        .we(we), .size(size), .ack(ack), .rdata(rdata), .err(err), .HSEL(HSEL),
        .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  who;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every ack pulse must match the oldest outstanding expectation.
    always @(negedge HCLK) begin
        if (HRESETn && ack != 2'b00) begin
            if (sb.size() == 0) begin
                chk("ack_unexpected", {62'd0, ack}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_who", {62'd0, ack}, {62'd0, e.who});
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("ack_err", {63'd0, err}, {63'd0, e.err});
                chk("ack_rdata", {32'd0, rdata}, {32'd0, e.rdata});
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic expect_ack(input logic [1:0] who, input int c, input logic e, input logic [31:0] rd);
        exp_t x;
        x.who = who; x.cyc = c; x.err = e; x.rdata = rd;
        sb.push_back(x);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] wd,
                           input logic w, input logic [2:0] s);
        addr[i] = a; wdata[i] = wd; we[i] = w; size[i] = s; req[i] = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_htrans"}, {62'd0, HTRANS}, 64'd0);
        chk({tag, "_haddr"}, {32'd0, HADDR}, 64'd0);
        chk({tag, "_hwrite"}, {63'd0, HWRITE}, 64'd0);
        chk({tag, "_hsize"}, {61'd0, HSIZE}, 64'd2);
        chk({tag, "_hwdata"}, {32'd0, HWDATA}, 64'd0);
        chk({tag, "_ack"}, {62'd0, ack}, 64'd0);
        chk({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    logic [31:0] bad_addr [3];
    logic [2:0]  bad_size [3];
    int c0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; req = '0; addr = '0; wdata = '0; we = '0; size = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        chk("hsel", {63'd0, HSEL}, 64'd1);
        chk("hburst", {61'd0, HBURST}, 64'd0);
        chk("hprot", {60'd0, HPROT}, 64'h3);
        chk("hmastlock", {63'd0, HMASTLOCK}, 64'd0);
        HRESETn = 1'b1;
        tick();

        // Zero-wait read by requester 0.
        HRDATA = 32'hDEADBEEF;
        c0 = cyc;
        set_req(0, 32'h100, 32'h0, 1'b0, 3'd2);
        expect_ack(2'b01, c0 + 3, 1'b0, 32'hDEADBEEF);
        tick();
        chk("rd_htrans_nonseq", {62'd0, HTRANS}, 64'h2);
        chk("rd_haddr", {32'd0, HADDR}, 64'h100);
        chk("rd_hwrite", {63'd0, HWRITE}, 64'd0);
        chk("rd_hsize", {61'd0, HSIZE}, 64'd2);
        tick();
        chk("rd_htrans_idle", {62'd0, HTRANS}, 64'd0);
        tick();
        req[0] = 1'b0;
        repeat (2) tick();

        // Write by requester 1 with 2 wait states in ADDR and 3 in DATA.
        c0 = cyc;
        set_req(1, 32'h204, 32'h12345678, 1'b1, 3'd2);
        expect_ack(2'b10, c0 + 8, 1'b0, 32'hDEADBEEF);
        tick();
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("wr_addr_htrans", {62'd0, HTRANS}, 64'h2);
            chk("wr_addr_haddr", {32'd0, HADDR}, 64'h204);
            chk("wr_addr_hwrite", {63'd0, HWRITE}, 64'd1);
            if (k == 2) HREADY = 1'b1;
            tick();
        end
        HREADY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("wr_data_htrans", {62'd0, HTRANS}, 64'd0);
            chk("wr_data_haddr", {32'd0, HADDR}, 64'h204);
            chk("wr_data_hwdata", {32'd0, HWDATA}, 64'h12345678);
            if (k == 3) HREADY = 1'b1;
            tick();
        end
        req[1] = 1'b0;
        repeat (2) tick();

        // Misaligned or oversized transfers fail without a bus cycle.
        bad_addr[0] = 32'h101; bad_size[0] = 3'd2;
        bad_addr[1] = 32'h102; bad_size[1] = 3'd2;
        bad_addr[2] = 32'h010; bad_size[2] = 3'd3;
        for (int v = 0; v < 3; v++) begin
            c0 = cyc;
            set_req(0, bad_addr[v], 32'h0, 1'b0, bad_size[v]);
            expect_ack(2'b01, c0 + 2, 1'b1, 32'hDEADBEEF);
            tick();
            chk("fail_no_nonseq", {62'd0, HTRANS}, 64'd0);
            tick();
            req[0] = 1'b0;
            tick();
        end

        // Two-cycle ERROR response, then an OKAY transfer clears err.
        c0 = cyc;
        set_req(0, 32'h300, 32'h0, 1'b0, 3'd2);
        expect_ack(2'b01, c0 + 4, 1'b1, 32'hBAD0BAD0);
        repeat (2) tick();
        HREADY = 1'b0; HRESP = 1'b1;
        tick();
        HREADY = 1'b1; HRDATA = 32'hBAD0BAD0;
        tick();
        req[0] = 1'b0; HRESP = 1'b0;
        tick();
        c0 = cyc;
        HRDATA = 32'h0000CAFE;
        set_req(0, 32'h8, 32'h0, 1'b0, 3'd1);
        expect_ack(2'b01, c0 + 3, 1'b0, 32'h0000CAFE);
        repeat (3) tick();
        req[0] = 1'b0;
        repeat (2) tick();

        // Both requesters held: grants 0,0,0,0,1,0,0,0,0,1.
        HRDATA = 32'h11112222;
        c0 = cyc;
        set_req(0, 32'h500, 32'h0, 1'b0, 3'd2);
        set_req(1, 32'h600, 32'h0, 1'b0, 3'd2);
        expect_ack(2'b01, c0 + 3,  1'b0, 32'h11112222);
        expect_ack(2'b01, c0 + 7,  1'b0, 32'h11112222);
        expect_ack(2'b01, c0 + 11, 1'b0, 32'h11112222);
        expect_ack(2'b01, c0 + 15, 1'b0, 32'h11112222);
        expect_ack(2'b10, c0 + 18, 1'b0, 32'h11112222);
        expect_ack(2'b01, c0 + 21, 1'b0, 32'h11112222);
        expect_ack(2'b01, c0 + 25, 1'b0, 32'h11112222);
        expect_ack(2'b01, c0 + 29, 1'b0, 32'h11112222);
        expect_ack(2'b01, c0 + 33, 1'b0, 32'h11112222);
        expect_ack(2'b10, c0 + 36, 1'b0, 32'h11112222);
        repeat (36) tick();
        req = 2'b00;
        repeat (3) tick();
        chk("fair_idle", {62'd0, HTRANS}, 64'd0);

        // Reset during the data phase abandons the transfer.
        c0 = cyc;
        set_req(0, 32'h400, 32'h0, 1'b0, 3'd2);
        repeat (2) tick();
        HREADY = 1'b0;
        tick();
        chk("rst_pre_haddr", {32'd0, HADDR}, 64'h400);
        HRESETn = 1'b0; req[0] = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        HREADY = 1'b1; HRESETn = 1'b1;
        repeat (4) tick();
        chk("midrst_no_ack_left", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
